sipo_deserializer: RTL and testbench

Parametrised serial-in/parallel-out deserializer, next generation of the team's 4-bit SIPO register. Collects WIDTH qualified serial bits into a word, with configurable bit order. Presents each completed word on a holding register with a valid/ready handshake and overrun detection. Sits between a bit-serial receiver front end and word-oriented consumer logic.

---
 rtl/sipo_pkg.sv | 13 +
 rtl/sipo_shift_core.sv | 42 ++++
 rtl/sipo_deserializer.sv | 85 ++++++++
 tb/tb_sipo_deserializer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the serial-in/parallel-out deserializer.
package sipo_pkg;

   // Bit-order selectors for the MSB_FIRST parameter
   localparam int unsigned BIT_ORDER_LSB_FIRST = 0;
   localparam int unsigned BIT_ORDER_MSB_FIRST = 1;

   // Width of a counter that must hold the values 0..width
   function automatic int unsigned count_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Parametrised shift register with enable and synchronous clear.
// next_word is the value the register takes on an enabled edge, i.e. the
// current contents with serial_in shifted in, so the caller can capture a
// completed word on the same edge that samples its last bit.
module sipo_shift_core
   import sipo_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MSB_FIRST = BIT_ORDER_MSB_FIRST
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic             serial_in,
   output logic [WIDTH-1:0] next_word
);

   logic [WIDTH-1:0] sreg;

   generate
      if (MSB_FIRST == BIT_ORDER_MSB_FIRST) begin : g_msb
         // First bit migrates toward the top of the word
         always_comb next_word = {sreg[WIDTH-2:0], serial_in};
      end else begin : g_lsb
         // First bit migrates toward bit 0
         always_comb next_word = {serial_in, sreg[WIDTH-1:1]};
      end
   endgenerate

   // Shift register state: clear beats enable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg <= '0;
      end else if (clear) begin
         sreg <= '0;
      end else if (enable) begin
         sreg <= next_word;
      end
   end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: collects WIDTH qualified bits, presents
// each completed word on a holding register with valid/ready handshake and a
// sticky overrun flag.
module sipo_deserializer
   import sipo_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MSB_FIRST = BIT_ORDER_MSB_FIRST
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          serial_in,
   input  logic                          in_valid,
   input  logic                          clear,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              parallel_out,
   output logic                          out_valid,
   output logic [count_width(WIDTH)-1:0] bit_count,
   output logic                          overrun
);

   localparam int unsigned CW = count_width(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   logic             shift_en;
   logic             complete;
   logic             transfer;
   logic [WIDTH-1:0] next_word;

   // Qualify the incoming bit and detect word completion / consumer transfer
   always_comb begin
      shift_en = in_valid && !clear;
      complete = shift_en && (bit_count == LAST_BIT);
      transfer = out_valid && out_ready;
   end

   sipo_shift_core #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift_core (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .enable    (shift_en),
      .serial_in (serial_in),
      .next_word (next_word)
   );

   // Bit counter: wraps to 0 on the completing bit, never reaches WIDTH
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_count <= '0;
      end else if (clear) begin
         bit_count <= '0;
      end else if (in_valid) begin
         bit_count <= complete ? '0 : bit_count + CW'(1);
      end
   end

   // Holding register and valid: a completion wins over a transfer, so a
   // simultaneous transfer+completion keeps out_valid high with the new word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parallel_out <= '0;
         out_valid    <= 1'b0;
      end else if (complete) begin
         parallel_out <= next_word;
         out_valid    <= 1'b1;
      end else if (transfer) begin
         out_valid    <= 1'b0;
      end
   end

   // Sticky overrun: set when a completed word replaces an unaccepted one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun <= 1'b0;
      end else if (clear) begin
         overrun <= 1'b0;
      end else if (complete && out_valid && !out_ready) begin
         overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench: one MSB-first and one LSB-first instance share the
// stimulus; a reference model tracks control state and expected words are
// queued when the completing bit is driven and popped when it is output.
module tb_sipo_deserializer;

   localparam int unsigned W  = 8;
   localparam int unsigned CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          serial_in;
   logic          in_valid;
   logic          clear;
   logic          out_ready;

   logic [W-1:0]  po_m, po_l;
   logic          ov_m, ov_l;
   logic          vld_m, vld_l;
   logic [CW-1:0] cnt_m, cnt_l;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Reference model state
   logic [W-1:0]  m_sreg_m, m_sreg_l;
   logic [W-1:0]  m_po_m, m_po_l;
   logic [CW-1:0] m_cnt;
   logic          m_valid, m_ov;
   logic [W-1:0]  q_m[$];
   logic [W-1:0]  q_l[$];

   always #5 clk = ~clk;

   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1)) u_dut_msb (
      .clk(clk), .rst(rst), .serial_in(serial_in), .in_valid(in_valid),
      .clear(clear), .out_ready(out_ready), .parallel_out(po_m),
      .out_valid(vld_m), .bit_count(cnt_m), .overrun(ov_m)
   );

   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(0)) u_dut_lsb (
      .clk(clk), .rst(rst), .serial_in(serial_in), .in_valid(in_valid),
      .clear(clear), .out_ready(out_ready), .parallel_out(po_l),
      .out_valid(vld_l), .bit_count(cnt_l), .overrun(ov_l)
   );

   task automatic check_value(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic model_reset();
      m_sreg_m = '0; m_sreg_l = '0; m_po_m = '0; m_po_l = '0;
      m_cnt = '0; m_valid = 1'b0; m_ov = 1'b0;
   endtask

   task automatic check_all(input string tag);
      check_value({tag, ":po_msb"},  32'(po_m),  32'(m_po_m));
      check_value({tag, ":po_lsb"},  32'(po_l),  32'(m_po_l));
      check_value({tag, ":vld_msb"}, 32'(vld_m), 32'(m_valid));
      check_value({tag, ":vld_lsb"}, 32'(vld_l), 32'(m_valid));
      check_value({tag, ":cnt_msb"}, 32'(cnt_m), 32'(m_cnt));
      check_value({tag, ":cnt_lsb"}, 32'(cnt_l), 32'(m_cnt));
      check_value({tag, ":ov_msb"},  32'(ov_m),  32'(m_ov));
      check_value({tag, ":ov_lsb"},  32'(ov_l),  32'(m_ov));
   endtask

   // Drive one cycle of inputs, advance the model, then check after the edge
   task automatic step(input logic sin, input logic vld, input logic clr,
                       input logic rdy, input string tag);
      logic compl;
      serial_in = sin; in_valid = vld; clear = clr; out_ready = rdy;
      compl = vld && !clr && (m_cnt == CW'(W - 1));
      if (clr) begin
         m_sreg_m = '0; m_sreg_l = '0; m_cnt = '0; m_ov = 1'b0;
      end else if (vld) begin
         m_sreg_m = {m_sreg_m[W-2:0], sin};
         m_sreg_l = {sin, m_sreg_l[W-1:1]};
         m_cnt    = compl ? '0 : m_cnt + CW'(1);
      end
      if (compl) begin
         q_m.push_back(m_sreg_m);
         q_l.push_back(m_sreg_l);
         if (m_valid && !rdy) m_ov = 1'b1;
         m_valid = 1'b1;
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (compl) begin
         m_po_m = q_m.pop_front();
         m_po_l = q_l.pop_front();
      end
      check_all(tag);
   endtask

   // Send a word first-bit-first from w[W-1] down; out_ready applies to the
   // last bit only, rdy_body to the others
   task automatic send_word(input logic [W-1:0] w, input logic rdy_body,
                            input logic rdy_last, input logic gaps, input string tag);
      for (int i = W - 1; i >= 0; i--) begin
         step(w[i], 1'b1, 1'b0, (i == 0) ? rdy_last : rdy_body, tag);
         if (gaps && i != 0) step(~w[i], 1'b0, 1'b0, rdy_body, {tag, "_gap"});
      end
   endtask

   initial begin
      rst = 1'b1; serial_in = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
      model_reset();
      #2;
      check_all("reset");
      #10;
      rst = 1'b0;

      // 1: MSB/LSB ordering, then a plain transfer
      send_word(8'hB2, 1'b0, 1'b0, 1'b0, "t1");
      check_value("t1_word_msb", 32'(po_m), 32'h0000_00B2);
      check_value("t2_word_lsb", 32'(po_l), 32'h0000_004D);
      check_value("t1_valid", 32'(vld_m), 32'h1);
      check_value("t1_cnt", 32'(cnt_m), 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b1, "t1_xfer");
      check_value("t1_hold", 32'(po_m), 32'h0000_00B2);
      check_value("t1_drained", 32'(vld_m), 32'h0);

      // 3: gaps with serial_in toggling
      send_word(8'hB2, 1'b0, 1'b0, 1'b1, "t3");
      check_value("t3_word", 32'(po_m), 32'h0000_00B2);

      // 4: overrun on unaccepted word, then clear
      send_word(8'hFF, 1'b0, 1'b0, 1'b0, "t4");
      check_value("t4_word", 32'(po_m), 32'h0000_00FF);
      check_value("t4_ovr", 32'(ov_m), 32'h1);
      step(1'b1, 1'b1, 1'b1, 1'b0, "t4_clear");
      check_value("t4_ovr_clr", 32'(ov_m), 32'h0);
      check_value("t4_valid_kept", 32'(vld_m), 32'h1);
      check_value("t4_word_kept", 32'(po_m), 32'h0000_00FF);

      // 5: transfer on the same edge as completion
      step(1'b0, 1'b0, 1'b0, 1'b1, "t5_drain");
      send_word(8'hB2, 1'b0, 1'b0, 1'b0, "t5a");
      send_word(8'h0F, 1'b0, 1'b1, 1'b0, "t5b");
      check_value("t5_word", 32'(po_m), 32'h0000_000F);
      check_value("t5_valid", 32'(vld_m), 32'h1);
      check_value("t5_no_ovr", 32'(ov_m), 32'h0);

      // clear on the would-be completing bit discards it; clear with transfer
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0, "clr_fill");
      step(1'b1, 1'b1, 1'b1, 1'b1, "clr_last");
      check_value("clr_no_word", 32'(po_m), 32'h0000_000F);
      check_value("clr_xfer", 32'(vld_m), 32'h0);

      // 6: async reset mid-word
      for (int i = 0; i < 5; i++) step(1'(i & 1), 1'b1, 1'b0, 1'b0, "t6_part");
      check_value("t6_cnt5", 32'(cnt_m), 32'h5);
      rst = 1'b1;
      #1;
      model_reset();
      check_all("t6_async_rst");
      #1;
      rst = 1'b0;
      send_word(8'hF0, 1'b0, 1'b0, 1'b0, "t6");
      check_value("t6_word", 32'(po_m), 32'h0000_00F0);
      check_value("t6_word_lsb", 32'(po_l), 32'h0000_000F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
